// File: rtl/decode_stage.sv
// RV32I decode stage: fetch/decode register, register file with write-through,
// control/ALU decoder, immediate extender and load-use hazard detection.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrF,
  input  logic [31:0]           PCF,
  input  logic [31:0]           PCPlus4F,
  input  logic                  PCSrcE,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ResultSrcE,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [31:0]           PCD,
  output logic [31:0]           PCPlus4D,
  output logic [31:0]           ImmExtD,
  output logic [4:0]            RdD,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic                  RegWriteD,
  output logic                  MemWriteD,
  output logic                  JumpD,
  output logic                  BranchD,
  output logic                  ALUSrcD,
  output logic [1:0]            ResultSrcD,
  output logic [2:0]            ALUControlD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushE
);

  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  logic [31:0]           instr_d;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  lw_stall;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       reg_write_raw;
  imm_sel_e   imm_sel;
  logic       alu_ok;
  logic [2:0] alu_op;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign RdD    = instr_d[11:7];
  assign Rs1D   = instr_d[19:15];
  assign Rs2D   = instr_d[24:20];

  // Fetch/decode register: flush has priority over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d  <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE) begin
      instr_d  <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (!StallD) begin
      instr_d  <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
    end
  end

  // Register file; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      regs[RdW] <= ResultW;
    end
  end

  // Reads bypass the write port so writeback and decode can share a cycle
  always_comb begin
    if (Rs1D == 5'd0)
      rd1 = '0;
    else if (RegWriteW && (RdW == Rs1D))
      rd1 = ResultW;
    else
      rd1 = regs[Rs1D];

    if (Rs2D == 5'd0)
      rd2 = '0;
    else if (RegWriteW && (RdW == Rs2D))
      rd2 = ResultW;
    else
      rd2 = regs[Rs2D];
  end

  // ALU op from funct3/funct7; SRA and unknown combinations are rejected
  always_comb begin
    alu_ok = 1'b0;
    alu_op = ALU_ADD;
    unique case (funct3)
      3'b000: begin
        if (funct7 == 7'b0000000 || opcode == OP_IALU) begin
          alu_ok = 1'b1;
          alu_op = ALU_ADD;
        end else if (funct7 == 7'b0100000) begin
          alu_ok = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      3'b001: begin
        alu_ok = (funct7 == 7'b0000000);
        alu_op = ALU_SLL;
      end
      3'b010: begin
        alu_ok = (funct7 == 7'b0000000) || (opcode == OP_IALU);
        alu_op = ALU_SLT;
      end
      3'b100: begin
        alu_ok = (funct7 == 7'b0000000) || (opcode == OP_IALU);
        alu_op = ALU_XOR;
      end
      3'b101: begin
        alu_ok = (funct7 == 7'b0000000);
        alu_op = ALU_SRL;
      end
      3'b110: begin
        alu_ok = (funct7 == 7'b0000000) || (opcode == OP_IALU);
        alu_op = ALU_OR;
      end
      3'b111: begin
        alu_ok = (funct7 == 7'b0000000) || (opcode == OP_IALU);
        alu_op = ALU_AND;
      end
      default: begin
        alu_ok = 1'b0;
        alu_op = ALU_ADD;
      end
    endcase
  end

  // Main decoder; anything unrecognised leaves every control at 0
  always_comb begin
    reg_write_raw = 1'b0;
    ResultSrcD    = 2'b00;
    MemWriteD     = 1'b0;
    ALUSrcD       = 1'b0;
    BranchD       = 1'b0;
    JumpD         = 1'b0;
    ALUControlD   = ALU_ADD;
    imm_sel       = IMM_NONE;
    unique case (opcode)
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_write_raw = 1'b1;
          ResultSrcD    = 2'b01;
          ALUSrcD       = 1'b1;
          imm_sel       = IMM_I;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          MemWriteD = 1'b1;
          ALUSrcD   = 1'b1;
          imm_sel   = IMM_S;
        end
      end
      OP_RTYPE: begin
        if (alu_ok) begin
          reg_write_raw = 1'b1;
          ALUControlD   = alu_op;
        end
      end
      OP_IALU: begin
        if (alu_ok) begin
          reg_write_raw = 1'b1;
          ALUSrcD       = 1'b1;
          ALUControlD   = alu_op;
          imm_sel       = IMM_I;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          BranchD     = 1'b1;
          ALUControlD = ALU_SUB;
          imm_sel     = IMM_B;
        end
      end
      OP_JAL: begin
        reg_write_raw = 1'b1;
        ResultSrcD    = 2'b10;
        JumpD         = 1'b1;
        imm_sel       = IMM_J;
      end
      default: begin
        reg_write_raw = 1'b0;
      end
    endcase
  end

  assign RegWriteD = reg_write_raw && (RdD != 5'd0);

  // Immediate extender, sign taken from bit 31
  always_comb begin
    unique case (imm_sel)
      IMM_I:   ImmExtD = {{20{instr_d[31]}}, instr_d[31:20]};
      IMM_S:   ImmExtD = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B:   ImmExtD = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                          instr_d[11:8], 1'b0};
      IMM_J:   ImmExtD = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                          instr_d[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

  // Load-use: raw field compare, conservative for instructions without rs2
  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushE = lw_stall | PCSrcE;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decode results are queued when an
// instruction is presented to fetch and compared once it reaches decode.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        PCSrcE, RegWriteW;
  logic [4:0]  RdW, RdE;
  logic [31:0] ResultW;
  logic [1:0]  ResultSrcE;
  logic [31:0] rd1, rd2, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  RdD, Rs1D, Rs2D;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        StallF, StallD, FlushE;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic [31:0] imm;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        alus;
    logic        br;
    logic        jmp;
    logic [2:0]  aluc;
  } exp_t;

  exp_t sb[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .PCSrcE(PCSrcE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .rd1(rd1), .rd2(rd2), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .StallF(StallF), .StallD(StallD), .FlushE(FlushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] imm,
                              input logic rw, input logic [1:0] rsrc,
                              input logic mw, input logic alus, input logic br,
                              input logic jmp, input logic [2:0] aluc);
    exp_t e;
    e.instr = instr; e.imm = imm; e.rw = rw; e.rsrc = rsrc; e.mw = mw;
    e.alus = alus; e.br = br; e.jmp = jmp; e.aluc = aluc;
    e.pcd = '0; e.pcp4 = '0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; InstrF = 32'h00A00093; PCF = 32'h40; PCPlus4F = 32'h44;
    PCSrcE = 0; RegWriteW = 0; RdW = 0; ResultW = 0; RdE = 0; ResultSrcE = 0;
    step(); step();
    checks++; if (dut.instr_d !== 32'h00000013) begin fails++; $display("FAIL reset_instr got %h want 00000013", dut.instr_d); end
    checks++; if (rd1 !== 32'd0 || rd2 !== 32'd0) begin fails++; $display("FAIL reset_rd got %h/%h want 0/0", rd1, rd2); end
    checks++; if (RegWriteD !== 1'b0 || ALUSrcD !== 1'b1) begin fails++; $display("FAIL reset_ctrl got rw=%b alus=%b want 0/1", RegWriteD, ALUSrcD); end
    checks++; if (StallF !== 1'b0 || StallD !== 1'b0 || FlushE !== 1'b0) begin fails++; $display("FAIL reset_hazard got %b%b%b want 000", StallF, StallD, FlushE); end
    checks++; if (PCD !== 32'd0 || PCPlus4D !== 32'd0 || ImmExtD !== 32'd0) begin fails++; $display("FAIL reset_pc got %h/%h/%h want 0", PCD, PCPlus4D, ImmExtD); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_decode();
    exp_t tbl[$];
    exp_t e;
    tbl.push_back(mk(32'h00500093, 32'd5,        1, 2'b00, 0, 1, 0, 0, 3'b000)); // addi
    tbl.push_back(mk(32'h0080A103, 32'd8,        1, 2'b01, 0, 1, 0, 0, 3'b000)); // lw
    tbl.push_back(mk(32'h010000EF, 32'd16,       1, 2'b10, 0, 0, 0, 1, 3'b000)); // jal
    tbl.push_back(mk(32'h402081B3, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b001)); // sub
    tbl.push_back(mk(32'h4020D1B3, 32'd0,        0, 2'b00, 0, 0, 0, 0, 3'b000)); // sra
    tbl.push_back(mk(32'h0030D213, 32'd3,        1, 2'b00, 0, 1, 0, 0, 3'b111)); // srli
    tbl.push_back(mk(32'h0020A2B3, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b101)); // slt
    tbl.push_back(mk(32'h0020C333, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b100)); // xor
    tbl.push_back(mk(32'h0020E1B3, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b011)); // or
    tbl.push_back(mk(32'h0020F1B3, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b010)); // and
    tbl.push_back(mk(32'h002091B3, 32'd0,        1, 2'b00, 0, 0, 0, 0, 3'b110)); // sll
    tbl.push_back(mk(32'h0020B1B3, 32'd0,        0, 2'b00, 0, 0, 0, 0, 3'b000)); // sltu
    tbl.push_back(mk(32'h00208033, 32'd0,        0, 2'b00, 0, 0, 0, 0, 3'b000)); // add x0
    tbl.push_back(mk(32'hFFF0C093, 32'hFFFFFFFF, 1, 2'b00, 0, 1, 0, 0, 3'b100)); // xori -1
    tbl.push_back(mk(32'h0000007F, 32'd0,        0, 2'b00, 0, 0, 0, 0, 3'b000)); // bad op
    tbl.push_back(mk(32'hFE000CE3, 32'hFFFFFFF8, 0, 2'b00, 0, 0, 1, 0, 3'b001)); // beq
    tbl.push_back(mk(32'h0020A623, 32'h0000000C, 0, 2'b00, 1, 1, 0, 0, 3'b000)); // sw
    tbl.push_back(mk(32'h00000013, 32'd0,        0, 2'b00, 0, 1, 0, 0, 3'b000)); // nop
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      e.pcd  = 32'h100 + 32'(i * 4);
      e.pcp4 = e.pcd + 32'd4;
      InstrF = e.instr; PCF = e.pcd; PCPlus4F = e.pcp4;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        checks++; fails++; $display("FAIL sb_empty at item %0d", i);
      end else begin
        e = sb.pop_front();
        checks++; if (ImmExtD !== e.imm) begin fails++; $display("FAIL imm[%h] got %h want %h", e.instr, ImmExtD, e.imm); end
        checks++; if (RegWriteD !== e.rw) begin fails++; $display("FAIL regwrite[%h] got %b want %b", e.instr, RegWriteD, e.rw); end
        checks++; if (ResultSrcD !== e.rsrc) begin fails++; $display("FAIL resultsrc[%h] got %b want %b", e.instr, ResultSrcD, e.rsrc); end
        checks++; if (MemWriteD !== e.mw) begin fails++; $display("FAIL memwrite[%h] got %b want %b", e.instr, MemWriteD, e.mw); end
        checks++; if (ALUSrcD !== e.alus) begin fails++; $display("FAIL alusrc[%h] got %b want %b", e.instr, ALUSrcD, e.alus); end
        checks++; if (BranchD !== e.br || JumpD !== e.jmp) begin fails++; $display("FAIL brjmp[%h] got %b%b want %b%b", e.instr, BranchD, JumpD, e.br, e.jmp); end
        checks++; if (ALUControlD !== e.aluc) begin fails++; $display("FAIL aluctrl[%h] got %b want %b", e.instr, ALUControlD, e.aluc); end
        checks++; if (RdD !== e.instr[11:7] || Rs1D !== e.instr[19:15] || Rs2D !== e.instr[24:20]) begin fails++; $display("FAIL fields[%h] got %0d/%0d/%0d", e.instr, RdD, Rs1D, Rs2D); end
        checks++; if (PCD !== e.pcd || PCPlus4D !== e.pcp4) begin fails++; $display("FAIL pc[%h] got %h/%h want %h/%h", e.instr, PCD, PCPlus4D, e.pcd, e.pcp4); end
      end
    end
  endtask

  task automatic test_writethrough();
    InstrF = 32'h000283B3; // add x7,x5,x0
    step();
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin fails++; $display("FAIL wt_same_cycle got %h want deadbeef", rd1); end
    checks++; if (rd2 !== 32'd0) begin fails++; $display("FAIL wt_rd2 got %h want 0", rd2); end
    step();
    RegWriteW = 0; ResultW = 32'h0;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin fails++; $display("FAIL wt_stored got %h want deadbeef", rd1); end
    RegWriteW = 1; RdW = 5'd0; ResultW = 32'h1234;
    #1;
    checks++; if (rd2 !== 32'd0) begin fails++; $display("FAIL x0_bypass got %h want 0", rd2); end
    step();
    RegWriteW = 0;
    #1;
    checks++; if (rd2 !== 32'd0 || rd1 !== 32'hDEADBEEF) begin fails++; $display("FAIL x0_stored got %h/%h want deadbeef/0", rd1, rd2); end
  endtask

  task automatic test_load_use();
    InstrF = 32'h001303B3; PCF = 32'h200; PCPlus4F = 32'h204; // add x7,x6,x1
    step();
    ResultSrcE = 2'b01; RdE = 5'd6;
    InstrF = 32'h00500093; PCF = 32'h204; PCPlus4F = 32'h208;
    #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b111) begin fails++; $display("FAIL lu_rs1 got %b%b%b want 111", StallF, StallD, FlushE); end
    step();
    checks++; if (dut.instr_d !== 32'h001303B3 || PCD !== 32'h200) begin fails++; $display("FAIL lu_hold got %h@%h want 001303b3@200", dut.instr_d, PCD); end
    RdE = 5'd1; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b111) begin fails++; $display("FAIL lu_rs2 got %b%b%b want 111", StallF, StallD, FlushE); end
    RdE = 5'd0; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin fails++; $display("FAIL lu_x0 got %b%b%b want 000", StallF, StallD, FlushE); end
    RdE = 5'd6; ResultSrcE = 2'b00; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin fails++; $display("FAIL lu_notload got %b%b%b want 000", StallF, StallD, FlushE); end
    ResultSrcE = 2'b01; #1;
  endtask

  task automatic test_flush_priority();
    PCSrcE = 1'b1; #1;
    checks++; if (FlushE !== 1'b1 || StallD !== 1'b1) begin fails++; $display("FAIL flush_event got flush=%b stall=%b want 1/1", FlushE, StallD); end
    step();
    PCSrcE = 1'b0; #1;
    checks++; if (dut.instr_d !== 32'h00000013 || PCD !== 32'd0 || PCPlus4D !== 32'd0) begin fails++; $display("FAIL flush_result got %h@%h want 00000013@0", dut.instr_d, PCD); end
    checks++; if (StallD !== 1'b0 || FlushE !== 1'b0) begin fails++; $display("FAIL flush_after got stall=%b flush=%b want 0/0", StallD, FlushE); end
    ResultSrcE = 2'b00; RdE = 5'd0;
  endtask

  task automatic test_reset_mid_stall();
    InstrF = 32'h001303B3; PCF = 32'h300; PCPlus4F = 32'h304;
    step();
    ResultSrcE = 2'b01; RdE = 5'd6; #2;
    rst = 1'b1; #1;
    checks++; if (dut.instr_d !== 32'h00000013 || PCD !== 32'd0 || StallD !== 1'b0) begin fails++; $display("FAIL rst_async got %h@%h stall=%b", dut.instr_d, PCD, StallD); end
    step();
    rst = 1'b0; ResultSrcE = 2'b00; RdE = 5'd0;
    InstrF = 32'h000283B3; // x5 was written earlier; reset must clear it
    step();
    checks++; if (rd1 !== 32'd0) begin fails++; $display("FAIL rst_regfile got %h want 0", rd1); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_writethrough();
    test_load_use();
    test_flush_priority();
    test_reset_mid_stall();
    if (sb.size() != 0) begin
      checks++; fails++; $display("FAIL sb_leftover %0d entries", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline; sits directly upstream of the decode/execute pipeline register and feeds it every operand and control field it latches.
- Contains the fetch/decode pipeline register (stall/flush), the 32x32 register file with write-through, the main/ALU control decoder, the immediate extender and load-use hazard detection.
- Produces the stall and flush signals for fetch, decode and the decode/execute register.

Parameters:
- DATA_WIDTH, 32, datapath width
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on reset/flush

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- InstrF  in  32  fetched instruction
- PCF  in  32  fetch PC
- PCPlus4F  in  32  fetch PC+4
- PCSrcE  in  1  taken branch/jump resolved in execute
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- RdE  in  5  destination of instruction in execute
- ResultSrcE  in  2  result select of instruction in execute (01 = load)
- rd1, rd2  out  32  register operands
- PCD, PCPlus4D  out  32  decode-stage PC, PC+4
- ImmExtD  out  32  sign-extended immediate
- RdD, Rs1D, Rs2D  out  5  instruction register fields
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  out  1  control
- ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlD  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
- StallF  out  1  hold PC
- StallD  out  1  hold fetch/decode register
- FlushE  out  1  flush decode/execute register

Behaviour:
- Fetch/decode register (InstrD, PCD, PCPlus4D):
  - rst: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - Each posedge, in priority order:
    1. PCSrcE=1: load NOP_INSTR and zero PCs. Flush beats stall.
    2. StallD=1: hold.
    3. Otherwise: load the F inputs.
- Register file:
  - rst clears all 32 entries to 0.
  - Write at posedge when RegWriteW=1 and RdW!=0; x0 is never written and always reads 0.
  - Reads are combinational on Rs1D=InstrD[19:15] and Rs2D=InstrD[24:20].
  - Write-through: if RegWriteW=1, RdW!=0 and RdW equals the read address, the read returns ResultW in the same cycle.
- Decoder is combinational on InstrD; RdD=InstrD[11:7].

| Instruction | RegWriteD | ResultSrcD | MemWriteD | ALUSrcD | BranchD | JumpD | ALUControlD |
|---|---|---|---|---|---|---|---|
| lw (0000011, f3=010) | 1 | 01 | 0 | 1 | 0 | 0 | ADD |
| sw (0100011, f3=010) | 0 | – | 1 | 1 | 0 | 0 | ADD |
| R-type (0110011) | 1 | 00 | 0 | 0 | 0 | 0 | from funct3/funct7 |
| I-ALU (0010011) | 1 | 00 | 0 | 1 | 0 | 0 | from funct3 |
| beq (1100011, f3=000) | 0 | – | 0 | 0 | 1 | 0 | SUB |
| jal (1101111) | 1 | 10 | 0 | 0 | 0 | 1 | – |

- ALU operation selection:
  - R-type: add/sub, and, or, xor, slt, sll, srl.
  - I-ALU: addi, andi, ori, xori, slti, slli, srli.
  - funct7[5]=1 with funct3=000 in R-type selects SUB.
  - SRA/SRAI and unsupported funct combinations decode as bubble.
- Any other opcode decodes as bubble: all controls 0, ALUControlD=000.
- RegWriteD is forced 0 when RdD=0.
- Immediate extension (sign bit InstrD[31]):
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
  - R-type and bubble: 0.
- Hazards:
  - lwStall = (ResultSrcE==01) && (RdE!=0) && (RdE==Rs1D || RdE==Rs2D). Raw field compare; conservative for instructions that do not use rs2.
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
- Reset values of outputs: InstrD decodes as NOP, giving:
  - all controls 0 except ALUSrcD=1;
  - ImmExtD=0, rd1=rd2=0, all 5-bit fields 0;
  - StallF=StallD=0; FlushE follows PCSrcE.
- Latency:
  - Control and operand outputs are valid the cycle after the instruction enters from fetch.
  - Hazard outputs are combinational.
- rst mid-stall or mid-flush: the asynchronous clear takes effect immediately, and the stalled instruction is lost.

Test Plan:
1. Reset: assert rst with InstrF=0x00A00093 -> InstrD=0x00000013, rd1=rd2=0, RegWriteD=0, ALUSrcD=1, StallF=0, PCD=0.
2. Write-through and x0:
   - RegWriteW=1, RdW=5, ResultW=0xDEADBEEF while InstrD=add x7,x5,x0 -> rd1=0xDEADBEEF in the same cycle, and again next cycle from storage.
   - RdW=0, ResultW=0x1234 -> rd2 reading x0 stays 0.
3. Load-use: ResultSrcE=01, RdE=6, InstrD=add x7,x6,x1 (0x001303B3) -> StallF=StallD=FlushE=1; InstrD unchanged after the edge. With RdE=0 -> no stall.
4. Flush priority: PCSrcE=1 together with lwStall=1 -> next cycle InstrD=0x00000013, PCD=0; FlushE=1 during the event.
5. Branch decode: InstrD=0xFE000CE3 (beq x0,x0,-8) -> ImmExtD=0xFFFFFFF8, BranchD=1, ALUControlD=001, RegWriteD=0.
6. Store decode: InstrD=0x0020A623 (sw x2,12(x1)) -> ImmExtD=0x0000000C, MemWriteD=1, ALUSrcD=1, RegWriteD=0, Rs1D=1, Rs2D=2.
